// File: rtl/raster_scheduler.sv
// raster_scheduler: frame-level controller for the rasterizer.
// Clears the wireframe framebuffer at frame start, then hands triangles from
// the upstream queue to the rasterizer one at a time, and arbitrates the single
// framebuffer write port between the clear engine and the rasterizer.
// Optional feature macro: RASTER_SCHED_WATCHDOG_EN (adds the wdog_err port and a
// per-triangle timeout in WAIT_DONE).
module raster_scheduler #(
    parameter int WIDTH       = 64,
    parameter int HEIGHT      = 48,
    parameter int ADDR_W      = 12,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              frame_start,
    input  logic [CNT_W-1:0]  num_tris,
    input  logic              clear_value,
    input  logic              tri_avail,
    output logic              tri_pop,
    output logic              tri_ready,
    input  logic              r_done,
    input  logic              r_write_en,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              r_data,
    output logic              cf_ready,
    output logic              fb_write_en,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_data,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  tri_count
`ifdef RASTER_SCHED_WATCHDOG_EN
    ,
    output logic              wdog_err
`endif
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W:0]   NPIX_X    = (ADDR_W + 1)'(NPIX);

    // Reject parameter sets where the framebuffer cannot be addressed.
    generate
        if (((2 ** ADDR_W) < NPIX) || (WDOG_CYCLES < 1)) begin : g_param_check
            $error("raster_scheduler: invalid ADDR_W or WDOG_CYCLES");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [CNT_W-1:0]    r_num;
    logic                r_clr_val;
    logic                r_done_q;
    logic [CNT_W-1:0]    r_tri_count;

    logic                w_start;
    logic                w_done_edge;
    logic                w_tri_end;
    logic                w_wr_in_range;
    logic                w_cnt_inc;
    logic [CNT_W-1:0]    w_cnt_plus;

    assign w_start       = (r_state == S_IDLE) && frame_start;
    assign w_done_edge   = r_done && !r_done_q;
    assign w_wr_in_range = ({1'b0, r_addr} < NPIX_X);
    assign w_cnt_plus    = r_tri_count + CNT_W'(1);
    assign busy          = (r_state != S_IDLE);
    assign tri_count     = r_tri_count;

`ifdef RASTER_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0]     r_wdog_cnt;
    logic                r_wdog_err;
    logic                w_timeout;

    // A triangle that never reports done is abandoned after WDOG_CYCLES cycles.
    assign w_timeout = (r_state == S_WAIT_DONE) && !w_done_edge &&
                       (r_wdog_cnt == WD_W'(WDOG_CYCLES - 1));
    assign w_tri_end = w_done_edge || w_timeout;
    assign wdog_err  = r_wdog_err;

    // Watchdog cycle counter restarts for every issued triangle; error is sticky per frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wdog_cnt <= '0;
            end else if (r_state == S_WAIT_DONE) begin
                r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
            end
            if (w_start) begin
                r_wdog_err <= 1'b0;
            end else if (w_timeout) begin
                r_wdog_err <= 1'b1;
            end
        end
    end
`else
    assign w_tri_end = w_done_edge;
`endif

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and write-port arbitration; clear engine owns the port in CLEAR,
    // the rasterizer only in WAIT_DONE.
    always_comb begin
        w_next      = r_state;
        tri_pop     = 1'b0;
        tri_ready   = 1'b0;
        cf_ready    = 1'b0;
        fb_write_en = 1'b0;
        fb_addr     = '0;
        fb_data     = 1'b0;
        frame_done  = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                fb_write_en = 1'b1;
                fb_addr     = r_clr_addr;
                fb_data     = r_clr_val;
                if (r_clr_addr == LAST_ADDR) begin
                    w_next = (r_num == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (tri_avail) begin
                    tri_pop = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tri_ready = 1'b1;
                w_next    = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                cf_ready = 1'b1;
                if (r_write_en && w_wr_in_range) begin
                    fb_write_en = 1'b1;
                    fb_addr     = r_addr;
                    fb_data     = r_data;
                end
                if (w_tri_end) begin
                    w_cnt_inc = 1'b1;
                    w_next    = (w_cnt_plus == r_num) ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                frame_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Frame parameters are captured on an accepted start; clear address walks the frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_clr_addr <= '0;
            r_num      <= '0;
            r_clr_val  <= 1'b0;
        end else if (w_start) begin
            r_clr_addr <= '0;
            r_num      <= num_tris;
            r_clr_val  <= clear_value;
        end else if (r_state == S_CLEAR) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
        end
    end

    // Triangle counter: zeroed on frame start, wraps naturally, holds after the frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tri_count <= '0;
        end else if (w_start) begin
            r_tri_count <= '0;
        end else if (w_cnt_inc) begin
            r_tri_count <= w_cnt_plus;
        end
    end

    // Done edge register: seeded in ISSUE so a level left high by the previous
    // triangle must fall and rise again before it counts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_done_q <= 1'b0;
        end else if ((r_state == S_ISSUE) || (r_state == S_WAIT_DONE)) begin
            r_done_q <= r_done;
        end
    end

endmodule

// File: tb/tb_raster_scheduler.sv
// Testbench for raster_scheduler: randomized frames checked against a
// pixel-memory model and transaction-level expectations of the frame sequence.
module tb_raster_scheduler;

    localparam int NPIX = 64 * 48;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        frame_start;
    logic [15:0] num_tris;
    logic        clear_value;
    logic        tri_avail;
    logic        tri_pop;
    logic        tri_ready;
    logic        r_done;
    logic        r_write_en;
    logic [11:0] r_addr;
    logic        r_data;
    logic        cf_ready;
    logic        fb_write_en;
    logic [11:0] fb_addr;
    logic        fb_data;
    logic        busy;
    logic        frame_done;
    logic [15:0] tri_count;

    int checks = 0;
    int errors = 0;

    logic exp_mem [NPIX];
    logic obs_mem [NPIX];
    int   nwr;
    int   exp_nwr;

    raster_scheduler dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .frame_start (frame_start),
        .num_tris    (num_tris),
        .clear_value (clear_value),
        .tri_avail   (tri_avail),
        .tri_pop     (tri_pop),
        .tri_ready   (tri_ready),
        .r_done      (r_done),
        .r_write_en  (r_write_en),
        .r_addr      (r_addr),
        .r_data      (r_data),
        .cf_ready    (cf_ready),
        .fb_write_en (fb_write_en),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .tri_count   (tri_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time limit, observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle sample point; every framebuffer write seen here lands in obs_mem.
    task automatic settle();
        @(negedge clk);
        if (fb_write_en === 1'b1) begin
            nwr++;
            if (int'(fb_addr) < NPIX) obs_mem[fb_addr] = fb_data;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ctl6();
        return {busy, tri_pop, tri_ready, cf_ready, frame_done, fb_write_en};
    endfunction

    task automatic start_frame(input int n, input logic cv);
        num_tris    = 16'(n);
        clear_value = cv;
        frame_start = 1'b1;
        tri_avail   = 1'($urandom);
        r_write_en  = 1'b1;
        r_addr      = 12'($urandom_range(0, NPIX - 1));
        r_data      = 1'($urandom);
        r_done      = 1'($urandom);
        nwr         = 0;
        exp_nwr     = NPIX;
        for (int i = 0; i < NPIX; i++) begin
            exp_mem[i] = cv;
            obs_mem[i] = ~cv;
        end
        settle();
        chk("idle_ctl", 32'(ctl6()), 32'h0);
        adv();
        frame_start = 1'b0;
    endtask

    task automatic clear_phase(input logic cv);
        for (int i = 0; i < NPIX; i++) begin
            frame_start = 1'($urandom);
            num_tris    = 16'($urandom);
            r_write_en  = 1'($urandom);
            r_addr      = 12'($urandom_range(0, NPIX - 1));
            r_data      = 1'($urandom);
            tri_avail   = 1'($urandom);
            r_done      = 1'($urandom);
            settle();
            chk("clear", 32'({fb_write_en, fb_addr, fb_data, busy, cf_ready, tri_pop, tri_ready, frame_done}),
                32'({1'b1, 12'(i), cv, 1'b1, 4'b0000}));
            adv();
        end
        frame_start = 1'b0;
    endtask

    task automatic fetch_phase(input int starve, input int cnt);
        for (int k = 0; k < starve; k++) begin
            tri_avail   = 1'b0;
            r_write_en  = 1'b1;
            r_addr      = 12'($urandom_range(0, NPIX - 1));
            r_data      = 1'($urandom);
            r_done      = 1'($urandom);
            frame_start = 1'($urandom);
            settle();
            chk("fetch_hold", 32'(ctl6()), 32'b100000);
            chk("fetch_cnt", 32'(tri_count), 32'(cnt));
            adv();
        end
        frame_start = 1'b0;
        tri_avail   = 1'b1;
        r_write_en  = 1'b1;
        settle();
        chk("pop", 32'(ctl6()), 32'b110000);
        adv();
    endtask

    task automatic issue_phase(input logic stale);
        tri_avail  = 1'($urandom);
        r_done     = stale;
        r_write_en = 1'b1;
        r_addr     = 12'($urandom_range(0, NPIX - 1));
        settle();
        chk("issue", 32'(ctl6()), 32'b101000);
        adv();
    endtask

    // Rasterizer side of one triangle: optional stale-high hold, a low stretch,
    // then the rising edge that completes the triangle.
    task automatic wait_phase(input logic stale, input int cnt, input int first_addr);
        int   hold;
        int   low;
        int   total;
        int   addr;
        int   sel;
        logic we;
        logic dat;
        logic fwd;
        hold  = stale ? int'($urandom_range(0, 3)) : 0;
        low   = stale ? int'($urandom_range(1, 6)) : int'($urandom_range(0, 6));
        total = hold + low + 1;
        for (int c = 0; c < total; c++) begin
            r_done      = (c < hold) ? 1'b1 : ((c < hold + low) ? 1'b0 : 1'b1);
            frame_start = 1'($urandom);
            tri_avail   = 1'($urandom);
            we          = 1'($urandom);
            sel         = int'($urandom_range(0, 3));
            if (sel == 0)      addr = NPIX;
            else if (sel == 1) addr = int'($urandom_range(NPIX + 1, 4095));
            else               addr = int'($urandom_range(0, NPIX - 1));
            dat = 1'($urandom);
            if (c == 0 && first_addr >= 0) begin
                we   = 1'b1;
                addr = first_addr;
                dat  = 1'b0;
            end
            fwd        = we && (addr < NPIX);
            r_write_en = we;
            r_addr     = 12'(addr);
            r_data     = dat;
            settle();
            chk("wait_ctl", 32'({busy, tri_pop, tri_ready, cf_ready, frame_done}), 32'b10010);
            chk("wait_fwd",
                32'({fb_write_en, (fb_write_en ? fb_addr : 12'd0), (fb_write_en ? fb_data : 1'b0)}),
                32'({fwd, (fwd ? 12'(addr) : 12'd0), (fwd ? dat : 1'b0)}));
            chk("wait_cnt", 32'(tri_count), 32'(cnt));
            if (fwd) begin
                exp_mem[addr] = dat;
                exp_nwr++;
            end
            adv();
        end
        frame_start = 1'b0;
    endtask

    task automatic finish_phase(input int n);
        int bad;
        frame_start = 1'b0;
        r_write_en  = 1'b1;
        r_addr      = 12'($urandom_range(0, NPIX - 1));
        tri_avail   = 1'b1;
        settle();
        chk("finish", 32'(ctl6()), 32'b100010);
        chk("fin_cnt", 32'(tri_count), 32'(n));
        adv();
        settle();
        chk("idle_after", 32'(ctl6()), 32'h0);
        chk("hold_cnt", 32'(tri_count), 32'(n));
        adv();
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (obs_mem[i] !== exp_mem[i]) bad++;
        end
        chk("mem_image", 32'(bad), 32'h0);
        chk("nwrites", 32'(nwr), 32'(exp_nwr));
    endtask

    task automatic run_frame(input int n, input logic cv, input int smin, input int smax, input int first_addr);
        logic stale;
        start_frame(n, cv);
        clear_phase(cv);
        for (int t = 0; t < n; t++) begin
            fetch_phase(int'($urandom_range(smin, smax)), t);
            stale = 1'($urandom);
            issue_phase(stale);
            wait_phase(stale, t, (t == 0) ? first_addr : -1);
        end
        finish_phase(n);
    endtask

    initial begin
        n_rst       = 1'b0;
        frame_start = 1'b0;
        num_tris    = '0;
        clear_value = 1'b0;
        tri_avail   = 1'b0;
        r_done      = 1'b0;
        r_write_en  = 1'b0;
        r_addr      = '0;
        r_data      = 1'b0;
        nwr         = 0;
        exp_nwr     = 0;
        #1;
        chk("reset_ctl", 32'(ctl6()), 32'h0);
        chk("reset_cnt", 32'(tri_count), 32'h0);
        adv();
        adv();
        n_rst = 1'b1;
        adv();

        // Clear-only frame.
        run_frame(0, 1'b1, 0, 0, -1);
        // Single triangle, immediate availability, directed write to pixel 100.
        run_frame(1, 1'b1, 0, 0, 100);
        // Upstream starvation between triangles.
        run_frame(3, 1'b0, 50, 50, -1);
        // Randomized frames.
        run_frame(int'($urandom_range(2, 5)), 1'($urandom), 0, 10, -1);
        run_frame(int'($urandom_range(2, 5)), 1'($urandom), 0, 10, -1);

        // Frame abandoned by reset in WAIT_DONE.
        start_frame(2, 1'b1);
        clear_phase(1'b1);
        fetch_phase(0, 0);
        issue_phase(1'b0);
        r_done     = 1'b0;
        r_write_en = 1'b1;
        r_addr     = 12'd5;
        r_data     = 1'b0;
        tri_avail  = 1'b1;
        settle();
        chk("pre_rst_fwd", 32'({cf_ready, fb_write_en, fb_addr}), 32'({1'b1, 1'b1, 12'd5}));
        n_rst = 1'b0;
        #1;
        chk("rst_async", 32'({ctl6(), tri_count}), 32'h0);
        for (int k = 0; k < 3; k++) begin
            adv();
            settle();
            chk("rst_hold", 32'({ctl6(), tri_count}), 32'h0);
        end
        n_rst = 1'b1;
        adv();
        run_frame(2, 1'b0, 0, 5, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/raster_scheduler.md
Name: raster_scheduler

Overview:
- Frame-level controller for the rasterizer.
- At each frame start it clears the wireframe buffer, then feeds triangles from the upstream triangle queue to the rasterizer one at a time.
- It owns the single framebuffer write port and arbitrates it between its internal clear engine and the rasterizer write stream.
- Sits between the triangle queue, the rasterizer and the wireframe framebuffer memory.

Parameters:
- WIDTH, 64, frame width in pixels
- HEIGHT, 48, frame height in pixels
- ADDR_W, 12, framebuffer address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT
- CNT_W, 16, triangle counter width
- WDOG_CYCLES, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle request to begin a frame
- num_tris  in  CNT_W  triangles in frame; sampled with frame_start
- clear_value  in  1  pixel value written during clear; sampled with frame_start
- tri_avail  in  1  upstream queue non-empty
- tri_pop  out  1  one-cycle dequeue strobe to upstream queue
- tri_ready  out  1  one-cycle start pulse to rasterizer
- r_done  in  1  rasterizer done level
- r_write_en  in  1  rasterizer pixel write request
- r_addr  in  ADDR_W  rasterizer pixel address
- r_data  in  1  rasterizer pixel value
- cf_ready  out  1  rasterizer write grant
- fb_write_en  out  1  framebuffer write strobe
- fb_addr  out  ADDR_W  framebuffer address
- fb_data  out  1  framebuffer write data
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle end-of-frame pulse
- tri_count  out  CNT_W  triangles completed this frame

Behaviour:
- Reset (async, n_rst=0):
  - State IDLE.
  - All outputs 0; tri_count=0.
  - Internal clear address, latched num_tris, latched clear_value and r_done edge register all cleared.
  - Reset asserted mid-frame abandons the frame with no frame_done.
- IDLE:
  - frame_start=1 latches num_tris and clear_value, zeroes tri_count and the clear address, then goes to CLEAR.
  - frame_start in any state other than IDLE is ignored.
- CLEAR (one write per cycle, starting the cycle after frame_start is sampled):
  - fb_write_en=1, fb_addr=clear address, fb_data=latched clear_value, cf_ready=0.
  - The address increments each cycle. After the write to WIDTH*HEIGHT-1, the FSM goes to FETCH, or to FINISH if latched num_tris==0.
  - The clear therefore takes exactly WIDTH*HEIGHT cycles.
- FETCH:
  - Waits for tri_avail=1.
  - The cycle tri_avail=1 is seen, tri_pop=1 for exactly that cycle and the FSM goes to ISSUE.
- ISSUE:
  - tri_ready=1 for exactly one cycle, then WAIT_DONE.
  - The r_done edge register is loaded with the current r_done so a stale high level is not counted.
- WAIT_DONE:
  - cf_ready=1.
  - Each r_write_en=1 with r_addr < WIDTH*HEIGHT is forwarded combinationally to fb_write_en/fb_addr/fb_data in the same cycle.
  - Out-of-range addresses are dropped (fb_write_en=0).
  - An r_done 0->1 transition increments tri_count.
  - If the new count equals latched num_tris, go to FINISH; otherwise go to FETCH.
  - A write and the done edge in the same cycle: the write is still forwarded.
- Outside WAIT_DONE:
  - r_write_en is ignored.
  - cf_ready=0, except in CLEAR, where fb_* is driven by the clear engine.
- FINISH: frame_done=1 for one cycle, then IDLE. tri_count holds its value until the next frame_start.
- Arithmetic:
  - tri_count wraps modulo 2**CNT_W; no saturation.
  - The clear address is ADDR_W wide.

Optional Feature:
- Macro: RASTER_SCHED_WATCHDOG_EN.
- When defined:
  - A cycle counter runs in WAIT_DONE.
  - If WDOG_CYCLES cycles elapse without an r_done edge, the triangle is abandoned: tri_count increments, a sticky output port wdog_err (1 bit) is set, and the FSM proceeds as on a normal done.
  - wdog_err clears only on reset or frame_start.
- When undefined: no wdog_err port, no counter; WAIT_DONE waits indefinitely.

Test Plan:
- Reset/clear: reset, frame_start with num_tris=0, clear_value=1.
  - Required: exactly 3072 fb writes, addr 0..3071, data 1.
  - Then frame_done pulses one cycle; busy falls with it.
- Single triangle: num_tris=1, tri_avail=1.
  - Required: tri_pop then tri_ready, one cycle each, on consecutive cycles after the clear.
  - Rasterizer writes addr 100 data 0 -> fb_write_en at addr 100.
  - r_done rising -> tri_count=1, frame_done.
- Upstream starvation: num_tris=3, tri_avail low for 50 cycles between triangles.
  - Required: FSM holds in FETCH with no tri_pop until tri_avail rises; tri_count ends at 3.
- Arbitration: drive r_write_en=1 during CLEAR and during FETCH.
  - Required: none forwarded; cf_ready=0.
  - r_addr=3072 in WAIT_DONE is dropped.
- Ignored start / stale done: frame_start asserted while busy has no effect.
  - r_done held high from the prior triangle does not count until it falls and rises again.
- Async reset mid-WAIT_DONE: n_rst low.
  - Required: all outputs 0 immediately and no frame_done.
  - A new frame_start afterwards runs normally.
  - Watchdog build: r_done never rises -> wdog_err=1 after 4096 cycles, frame completes.
